// File: rtl/hazard_pkg.sv
// ============================================================================
// Module : hazard_pkg
// Shared types for the pipeline sequencing controller: FSM states and the
// bundle of stage enables, flushes and the mul/div start pulse.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MD_WAIT  = 2'd1,
        MEM_WAIT = 2'd2
    } state_e;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic mem_wb_en;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_flush;
        logic md_go;
    } ctrl_t;

    // Field order: pc, if_id, id_ex, ex_mem, mem_wb | if_id_fl, id_ex_fl, ex_mem_fl | md_go
    localparam ctrl_t C_CTRL_OFF      = ctrl_t'(9'b00000_000_0);
    localparam ctrl_t C_CTRL_RUN      = ctrl_t'(9'b11111_000_0);
    localparam ctrl_t C_CTRL_MD_START = ctrl_t'(9'b00011_001_1);
    localparam ctrl_t C_CTRL_MD_HOLD  = ctrl_t'(9'b00011_001_0);
    localparam ctrl_t C_CTRL_BUBBLE   = ctrl_t'(9'b00111_010_0);
    localparam ctrl_t C_CTRL_BRANCH   = ctrl_t'(9'b11111_110_0);

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// Module : sat_counter
// Up-counter that sticks at all-ones; synchronous clear wins over increment.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module : hazard_ctrl
// Stall/flush sequencer for the 5-stage core: load-use, branch, mul/div and
// data-memory waits resolved with fixed priority; stall/flush perf counters.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int REG_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [REG_W-1:0] id_rs1_i,
    input  logic [REG_W-1:0] id_rs2_i,
    input  logic             id_uses_rs1_i,
    input  logic             id_uses_rs2_i,
    input  logic             ex_mem_read_i,
    input  logic [REG_W-1:0] ex_rd_i,
    input  logic             ex_branch_taken_i,
    input  logic             ex_md_i,
    input  logic             md_done_i,
    input  logic             mem_req_i,
    input  logic             mem_ready_i,
    input  logic             cnt_clr_i,
    output logic             pc_en_o,
    output logic             if_id_en_o,
    output logic             id_ex_en_o,
    output logic             ex_mem_en_o,
    output logic             mem_wb_en_o,
    output logic             if_id_flush_o,
    output logic             id_ex_flush_o,
    output logic             ex_mem_flush_o,
    output logic             md_go_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    state_e state_q;
    state_e state_d;
    ctrl_t  w_ctrl;
    logic   w_load_use;
    logic   w_branch;

    assign w_load_use = ex_mem_read_i && (ex_rd_i != '0) &&
                        ((id_uses_rs1_i && (id_rs1_i == ex_rd_i)) ||
                         (id_uses_rs2_i && (id_rs2_i == ex_rd_i)));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        w_ctrl   = C_CTRL_OFF;
        w_branch = 1'b0;
        state_d  = state_q;
        if (state_q == MD_WAIT) begin
            if (md_done_i) begin
                w_ctrl  = C_CTRL_RUN;
                state_d = RUN;
            end else begin
                w_ctrl  = C_CTRL_MD_HOLD;
            end
        end else if ((state_q == MEM_WAIT) && !mem_ready_i) begin
            w_ctrl  = C_CTRL_OFF;
        end else begin
            // RUN rules; also the MEM_WAIT completion cycle, where mem_ready=1
            // makes the memory-wait rule false on its own. Illegal code 3 lands here.
            state_d = RUN;
            if (mem_req_i && !mem_ready_i) begin
                w_ctrl  = C_CTRL_OFF;
                state_d = MEM_WAIT;
            end else if (ex_md_i) begin
                w_ctrl  = C_CTRL_MD_START;
                state_d = MD_WAIT;
            end else if (w_load_use) begin
                w_ctrl  = C_CTRL_BUBBLE;
            end else if (ex_branch_taken_i) begin
                w_ctrl   = C_CTRL_BRANCH;
                w_branch = 1'b1;
            end else begin
                w_ctrl  = C_CTRL_RUN;
            end
        end
        if (rst_i) begin
            w_ctrl   = C_CTRL_OFF;
            w_branch = 1'b0;
        end
    end

    assign pc_en_o        = w_ctrl.pc_en;
    assign if_id_en_o     = w_ctrl.if_id_en;
    assign id_ex_en_o     = w_ctrl.id_ex_en;
    assign ex_mem_en_o    = w_ctrl.ex_mem_en;
    assign mem_wb_en_o    = w_ctrl.mem_wb_en;
    assign if_id_flush_o  = w_ctrl.if_id_flush;
    assign id_ex_flush_o  = w_ctrl.id_ex_flush;
    assign ex_mem_flush_o = w_ctrl.ex_mem_flush;
    assign md_go_o        = w_ctrl.md_go;
    assign state_o        = state_q;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (!w_ctrl.pc_en),
        .clr_i (cnt_clr_i),
        .cnt_o (stall_cnt_o)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (w_branch),
        .clr_i (cnt_clr_i),
        .cnt_o (flush_cnt_o)
    );

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// Module : tb_hazard_ctrl
// Directed and random stimulus against an action-level reference model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

    localparam int CNT_W = 8;
    localparam int REG_W = 5;
    localparam int SAT   = (1 << CNT_W) - 1;

    // model actions, each mapped to a fixed output vector
    localparam int A_FREEZE = 0, A_MD_START = 1, A_MD_HOLD = 2, A_BUBBLE = 3,
                   A_BRANCH = 4, A_NORMAL = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic [REG_W-1:0] id_rs1, id_rs2, ex_rd;
    logic             id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken;
    logic             ex_md, md_done, mem_req, mem_ready, cnt_clr;
    logic             pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic             if_id_flush, id_ex_flush, ex_mem_flush, md_go;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;
    int m_state, m_stall, m_flush;

    always #10 clk = ~clk;

    hazard_ctrl #(.CNT_W(CNT_W), .REG_W(REG_W)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .id_rs1_i          (id_rs1),
        .id_rs2_i          (id_rs2),
        .id_uses_rs1_i     (id_uses_rs1),
        .id_uses_rs2_i     (id_uses_rs2),
        .ex_mem_read_i     (ex_mem_read),
        .ex_rd_i           (ex_rd),
        .ex_branch_taken_i (ex_branch_taken),
        .ex_md_i           (ex_md),
        .md_done_i         (md_done),
        .mem_req_i         (mem_req),
        .mem_ready_i       (mem_ready),
        .cnt_clr_i         (cnt_clr),
        .pc_en_o           (pc_en),
        .if_id_en_o        (if_id_en),
        .id_ex_en_o        (id_ex_en),
        .ex_mem_en_o       (ex_mem_en),
        .mem_wb_en_o       (mem_wb_en),
        .if_id_flush_o     (if_id_flush),
        .id_ex_flush_o     (id_ex_flush),
        .ex_mem_flush_o    (ex_mem_flush),
        .md_go_o           (md_go),
        .state_o           (state),
        .stall_cnt_o       (stall_cnt),
        .flush_cnt_o       (flush_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {pc, if_id, id_ex, ex_mem, mem_wb, fl_if_id, fl_id_ex, fl_ex_mem, md_go}
    function automatic logic [8:0] action_vec(input int a);
        case (a)
            A_FREEZE:   return 9'b00000_000_0;
            A_MD_START: return 9'b00011_001_1;
            A_MD_HOLD:  return 9'b00011_001_0;
            A_BUBBLE:   return 9'b00111_010_0;
            A_BRANCH:   return 9'b11111_110_0;
            default:    return 9'b11111_000_0;
        endcase
    endfunction

    function automatic int pick_action();
        bit hit1 = id_uses_rs1 && (id_rs1 == ex_rd);
        bit hit2 = id_uses_rs2 && (id_rs2 == ex_rd);
        bit lu   = ex_mem_read && (ex_rd != 0) && (hit1 || hit2);
        if (m_state == 1) return md_done ? A_NORMAL : A_MD_HOLD;
        if (m_state == 2 && !mem_ready) return A_FREEZE;
        if (mem_req && !mem_ready) return A_FREEZE;
        if (ex_md) return A_MD_START;
        if (lu) return A_BUBBLE;
        if (ex_branch_taken) return A_BRANCH;
        return A_NORMAL;
    endfunction

    task automatic idle();
        id_rs1 = 0; id_rs2 = 0; ex_rd = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        ex_mem_read = 0; ex_branch_taken = 0; ex_md = 0; md_done = 0;
        mem_req = 0; mem_ready = 1; cnt_clr = 0;
    endtask

    task automatic model_reset();
        m_state = 0; m_stall = 0; m_flush = 0;
    endtask

    // Inputs are already applied; check at negedge, advance model at posedge.
    task automatic cycle();
        int a;
        logic [8:0] v;
        @(negedge clk);
        a = pick_action();
        v = action_vec(a);
        check("ctrl", {55'd0, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                       if_id_flush, id_ex_flush, ex_mem_flush, md_go}, {55'd0, v});
        check("state", {62'd0, state}, m_state);
        check("stall_cnt", {56'd0, stall_cnt}, m_stall);
        check("flush_cnt", {56'd0, flush_cnt}, m_flush);
        @(posedge clk);
        if (a == A_FREEZE) m_state = 2;
        else if (a == A_MD_START || a == A_MD_HOLD) m_state = 1;
        else m_state = 0;
        if (cnt_clr) begin
            m_stall = 0;
            m_flush = 0;
        end else begin
            if (!v[8] && m_stall < SAT) m_stall++;
            if (a == A_BRANCH && m_flush < SAT) m_flush++;
        end
        #1;
    endtask

    initial begin
        int s0;
        idle();
        rst = 1'b1;
        model_reset();
        #3;
        check("rst_ctrl", {55'd0, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                           if_id_flush, id_ex_flush, ex_mem_flush, md_go}, 0);
        check("rst_state", {62'd0, state}, 0);
        check("rst_cnt", {48'd0, stall_cnt, flush_cnt}, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // load-use, then same with ex_rd=0
        ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_uses_rs1 = 1;
        cycle();
        check("lu_stall_cnt", {56'd0, stall_cnt}, 1);
        ex_rd = 0; id_rs1 = 0;
        cycle();
        check("lu_rd0_no_stall", {56'd0, stall_cnt}, 1);
        idle();

        ex_branch_taken = 1;
        cycle();
        check("branch_flush_cnt", {56'd0, flush_cnt}, 1);
        idle();

        // mul/div, done at T+3
        s0 = m_stall;
        ex_md = 1;
        cycle();
        ex_md = 0;
        cycle();
        cycle();
        md_done = 1;
        cycle();
        md_done = 0;
        check("md_stall_delta", {56'd0, stall_cnt}, s0 + 3);
        check("md_back_to_run", {62'd0, state}, 0);

        // memory wait with load-use pending
        mem_req = 1; mem_ready = 0;
        ex_mem_read = 1; ex_rd = 7; id_rs2 = 7; id_uses_rs2 = 1;
        cycle();
        check("mem_wait_state", {62'd0, state}, 2);
        cycle();
        mem_ready = 1;
        cycle();
        check("mem_exit_state", {62'd0, state}, 0);
        idle();

        // asynchronous reset in MD_WAIT
        ex_md = 1;
        cycle();
        ex_md = 0;
        cycle();
        check("pre_rst_state", {62'd0, state}, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_state", {62'd0, state}, 0);
        check("arst_md_go_pc", {62'd0, md_go, pc_en}, 0);
        check("arst_cnt", {48'd0, stall_cnt, flush_cnt}, 0);
        #1 rst = 1'b0;
        model_reset();
        cycle();

        // saturation and clear
        ex_md = 1;
        cycle();
        ex_md = 0;
        repeat (SAT + 5) cycle();
        check("stall_saturated", {56'd0, stall_cnt}, SAT);
        cnt_clr = 1;
        cycle();
        cnt_clr = 0;
        check("clr_over_inc", {56'd0, stall_cnt}, 0);
        md_done = 1;
        cycle();
        idle();

        repeat (500) begin
            id_rs1          = REG_W'($urandom_range(0, 3));
            id_rs2          = REG_W'($urandom_range(0, 3));
            ex_rd           = REG_W'($urandom_range(0, 3));
            id_uses_rs1     = 1'($urandom_range(0, 1));
            id_uses_rs2     = 1'($urandom_range(0, 1));
            ex_mem_read     = ($urandom_range(0, 3) == 0);
            ex_branch_taken = ($urandom_range(0, 3) == 0);
            ex_md           = ($urandom_range(0, 9) == 0);
            md_done         = ($urandom_range(0, 2) == 0);
            mem_req         = ($urandom_range(0, 2) == 0);
            mem_ready       = ($urandom_range(0, 9) < 6);
            cnt_clr         = ($urandom_range(0, 49) == 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
